mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Responder side of the control unit's memory strobes: MAR_in, MDR_in, MDR_out, RAM_enable_read and RAM_enable_write.
- Owns the MAR and MDR registers and sequences single-word reads and writes against a synchronous block RAM with fixed read latency.
- Drives MDR onto the internal bus and returns a one-cycle mem_done pulse so the control unit can advance past memory micro-steps.

Parameters:
- DATA_W, 16, word width of bus, MDR and RAM data.
- ADDR_W, 12, RAM address width; MAR loads bus[ADDR_W-1:0].
- READ_LAT, 1, RAM cycles from ram_re edge to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  internal data bus value.
- MAR_in  in  1  load MAR from bus_in.
- MDR_in  in  1  load MDR from bus_in.
- MDR_out  in  1  drive MDR onto bus_out.
- RAM_enable_read  in  1  read request, level.
- RAM_enable_write  in  1  write request, level.
- bus_out  out  DATA_W  MDR value when MDR_out=1, else 0.
- bus_out_en  out  1  equals MDR_out (combinational).
- mem_done  out  1  one-cycle completion pulse.
- busy  out  1  state != IDLE.
- proto_err  out  1  sticky protocol-violation flag; cleared only by reset.
- ram_addr  out  ADDR_W  RAM address; registered, equals MAR.
- ram_wdata  out  DATA_W  RAM write data; equals MDR.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset values:
  - MAR=0, MDR=0, state=IDLE, counter=0.
  - mem_done=0, ram_re=0, ram_we=0, proto_err=0, busy=0.
  - bus_out=0 unless MDR_out=1.
- Reset mid-operation: same-edge abort to IDLE; ram_re/ram_we drop; no mem_done.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- IDLE:
  - MAR_in=1 loads MAR; MDR_in=1 loads MDR.
  - RAM_enable_read=1 -> RD_ISSUE.
  - Else RAM_enable_write=1 -> WR_ISSUE.
  - Read and write both 1: read wins, proto_err set.
  - Loads and a request on the same edge: loads take effect first, so the access uses the new MAR/MDR.
- RD_ISSUE (1 cycle): ram_re=1; counter loaded with READ_LAT -> RD_WAIT.
- RD_WAIT:
  - Decrements counter.
  - When counter reaches 0, captures ram_rdata into MDR -> DONE.
- WR_ISSUE (1 cycle): ram_we=1 with ram_addr=MAR, ram_wdata=MDR -> DONE.
- DONE (1 cycle): mem_done=1 -> IDLE; requests are ignored in this state.
- Latency, with request sampled at edge E0:
  - Read: mem_done is high in the cycle after E(READ_LAT+2). READ_LAT=1 gives 3 edges.
  - Write: mem_done is high in the cycle after E1.
- Request hold:
  - Requests are levels; the control unit drops them on seeing mem_done.
  - A request still high when DONE returns to IDLE starts a new access.
- Busy violations (MAR_in or MDR_in asserted while busy):
  - The load is ignored and proto_err is set.
  - MAR and MDR are stable throughout any access.
- MDR_out is honoured in any state. bus_out shows the pre-capture MDR until the RD_WAIT->DONE edge.
- No address or data arithmetic; MAR truncates the upper bus bits.

Decomposition:
- Package fpg8_mem_pkg holds:
  - state enum: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
  - DATA_W/ADDR_W default constants.
  - counter width constant of 3 bits.
- No sub-module; the latency counter stays inline.
- The bench instantiates a behavioural sync RAM model with matching READ_LAT.

Test Plan:
- Reset then idle:
  - Stimulus: reset for 2 cycles.
  - Required: all outputs 0, busy=0, proto_err=0, and bus_out=0 with MDR_out=0.
- Write then read back, READ_LAT=1:
  - Stimulus: bus_in=0x0123 with MAR_in; bus_in=0xBEEF with MDR_in; RAM_enable_write.
  - Required: ram_we for 1 cycle at addr 0x123; mem_done 1 edge later.
  - Stimulus: then RAM_enable_read.
  - Required: MDR=0xBEEF and mem_done exactly 3 edges after the request; MDR_out drives bus_out=0xBEEF.
- Latency sweep:
  - Stimulus: READ_LAT=4, read of addr 0x0FF preloaded with 0x5A5A.
  - Required: mem_done exactly 6 edges after request; ram_re high exactly 1 cycle.
- Simultaneous read+write in IDLE:
  - Required: read performed, ram_we never asserted, proto_err=1 and held until reset.
- Load while busy:
  - Stimulus: MAR_in with bus_in=0x0777 during RD_WAIT.
  - Required: ram_addr and MAR unchanged, proto_err=1, read completes normally.
- Reset mid-read:
  - Stimulus: reset asserted in RD_WAIT.
  - Required: next cycle state IDLE, MDR=0, no mem_done pulse; a subsequent read succeeds.

Source files
------------

// File: rtl/fpg8_mem_pkg.sv
// Shared types and sizing constants for the memory bus responder.
package fpg8_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      DONE
   } mem_state_e;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 12;
   localparam int CNT_W      = 3;

endpackage

// File: rtl/mem_bus_unit.sv
// Responder for the control unit's memory strobes: owns MAR/MDR and sequences
// single-word accesses against a fixed-latency synchronous RAM.
module mem_bus_unit
   import fpg8_mem_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              MAR_in,
   input  logic              MDR_in,
   input  logic              MDR_out,
   input  logic              RAM_enable_read,
   input  logic              RAM_enable_write,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_out_en,
   output logic              mem_done,
   output logic              busy,
   output logic              proto_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic              err_q, err_d;

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      re_d    = 1'b0;
      we_d    = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            // Loads land on the same edge as the request, so the access sees them.
            if (MAR_in) mar_d = bus_in[ADDR_W-1:0];
            if (MDR_in) mdr_d = bus_in;
            if (RAM_enable_read) begin
               state_d = RD_ISSUE;
               re_d    = 1'b1;
               if (RAM_enable_write) err_d = 1'b1;
            end else if (RAM_enable_write) begin
               state_d = WR_ISSUE;
               we_d    = 1'b1;
            end
         end
         RD_ISSUE: begin
            cnt_d   = CNT_W'(READ_LAT);
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               mdr_d   = ram_rdata;
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WR_ISSUE: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Register loads during an access are dropped and flagged.
      if ((state_q != IDLE) && (MAR_in || MDR_in)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         re_q    <= re_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign bus_out    = MDR_out ? mdr_q : '0;
   assign bus_out_en = MDR_out;
   assign mem_done   = done_q;
   assign busy       = (state_q != IDLE);
   assign proto_err  = err_q;
   assign ram_addr   = mar_q;
   assign ram_wdata  = mdr_q;
   assign ram_re     = re_q;
   assign ram_we     = we_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: two instances (READ_LAT 1 and 4), each with its own sync RAM model.
module tb_mem_bus_unit;

   localparam int DW = 16;
   localparam int AW = 12;

   typedef struct {
      int         done_cyc;
      logic [15:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] bus_in [2];
   logic          mar_in [2];
   logic          mdr_in [2];
   logic          mdr_out [2];
   logic          rd [2];
   logic          wr [2];
   logic [DW-1:0] bus_out [2];
   logic          bus_out_en [2];
   logic          mem_done [2];
   logic          busy [2];
   logic          proto_err [2];
   logic [AW-1:0] ram_addr [2];
   logic [DW-1:0] ram_wdata [2];
   logic [DW-1:0] ram_rdata [2];
   logic          ram_re [2];
   logic          ram_we [2];

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : 4;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bus_unit #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT((g == 0) ? 1 : 4)) u_dut (
         .clk(clk), .reset(reset), .bus_in(bus_in[g]),
         .MAR_in(mar_in[g]), .MDR_in(mdr_in[g]), .MDR_out(mdr_out[g]),
         .RAM_enable_read(rd[g]), .RAM_enable_write(wr[g]),
         .bus_out(bus_out[g]), .bus_out_en(bus_out_en[g]), .mem_done(mem_done[g]),
         .busy(busy[g]), .proto_err(proto_err[g]), .ram_addr(ram_addr[g]),
         .ram_wdata(ram_wdata[g]), .ram_re(ram_re[g]), .ram_we(ram_we[g]),
         .ram_rdata(ram_rdata[g])
      );
   end

   // Sync RAM: data appears lat_of(i) edges after the ram_re edge and then holds;
   // intermediate cycles show a poison value so early capture is visible.
   logic [DW-1:0] mem [2][4096];
   logic [DW-1:0] pend [2];
   int            pcnt [2];
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ram_we[i]) mem[i][ram_addr[i]] <= ram_wdata[i];
         if (ram_re[i]) begin
            if (lat_of(i) == 1) ram_rdata[i] <= mem[i][ram_addr[i]];
            else begin
               ram_rdata[i] <= 16'hDEAD;
               pend[i]      <= mem[i][ram_addr[i]];
               pcnt[i]      <= lat_of(i) - 1;
            end
         end else if (pcnt[i] > 0) begin
            pcnt[i] <= pcnt[i] - 1;
            if (pcnt[i] == 1) ram_rdata[i] <= pend[i];
         end
      end
   end

   // All stimulus tasks start and end just after a falling edge.
   task automatic do_load(input int s, input logic [15:0] v, input logic m_mar, input logic m_mdr);
      bus_in[s] = v; mar_in[s] = m_mar; mdr_in[s] = m_mdr;
      @(negedge clk);
      mar_in[s] = 1'b0; mdr_in[s] = 1'b0;
   endtask

   task automatic run_req(input int s, input logic r, input logic w, output int done_at,
                          output logic [15:0] bus_first, output logic [15:0] bus_done,
                          output int nre, output int nwe, output logic [11:0] we_addr,
                          output logic post_done);
      rd[s] = r; wr[s] = w; mdr_out[s] = 1'b1;
      done_at = -1; bus_first = 'x; bus_done = 'x; nre = 0; nwe = 0; we_addr = '0; post_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) bus_first = bus_out[s];
         if (ram_re[s]) nre++;
         if (ram_we[s]) begin nwe++; we_addr = ram_addr[s]; end
         if (mem_done[s]) begin done_at = cyc; bus_done = bus_out[s]; break; end
      end
      rd[s] = 1'b0; wr[s] = 1'b0;
      @(negedge clk);
      post_done = mem_done[s];
      mdr_out[s] = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         total++;
         if ({mem_done[s], busy[s], proto_err[s], ram_re[s], ram_we[s], bus_out_en[s]} !== 6'b0) begin
            bad++; $display("FAIL reset_flags[%0d] got=%b want=000000", s,
               {mem_done[s], busy[s], proto_err[s], ram_re[s], ram_we[s], bus_out_en[s]});
         end
         total++;
         if ({bus_out[s], ram_wdata[s], ram_addr[s]} !== 44'h0) begin
            bad++; $display("FAIL reset_data[%0d] got=%h/%h/%h want=0", s, bus_out[s], ram_wdata[s], ram_addr[s]);
         end
      end
      mdr_out[0] = 1'b1;
      #1;
      total++;
      if (bus_out[0] !== 16'h0 || bus_out_en[0] !== 1'b1) begin
         bad++; $display("FAIL reset_mdr_out got=%h en=%b want=0000 en=1", bus_out[0], bus_out_en[0]);
      end
      mdr_out[0] = 1'b0;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int d; int nre; int nwe; logic [15:0] bf; logic [15:0] bd; logic [11:0] wa; logic pd; exp_t e;
      do_load(0, 16'h0123, 1'b1, 1'b0);
      do_load(0, 16'hBEEF, 1'b0, 1'b1);
      sb.push_back('{cyc + 2, 16'hBEEF});
      run_req(0, 1'b0, 1'b1, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", d, e.done_cyc); end
      total++;
      if (nwe !== 1 || wa !== 12'h123 || nre !== 0) begin
         bad++; $display("FAIL wr_strobe got we=%0d addr=%h re=%0d want we=1 addr=123 re=0", nwe, wa, nre);
      end
      total++;
      if (pd !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%b want=0", pd); end
      do_load(0, 16'h0000, 1'b0, 1'b1);
      sb.push_back('{cyc + 4, 16'hBEEF});
      run_req(0, 1'b1, 1'b0, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc) begin bad++; $display("FAIL rd1_latency got=%0d want=%0d", d, e.done_cyc); end
      total++;
      if (bd !== e.data) begin bad++; $display("FAIL rd1_data got=%h want=%h", bd, e.data); end
      total++;
      if (nre !== 1 || nwe !== 0 || pd !== 1'b0) begin
         bad++; $display("FAIL rd1_strobe got re=%0d we=%0d post=%b want 1 0 0", nre, nwe, pd);
      end
   endtask

   task automatic test_latency();
      int d; int nre; int nwe; logic [15:0] bf; logic [15:0] bd; logic [11:0] wa; logic pd; exp_t e;
      do_load(1, 16'hF0FF, 1'b1, 1'b0);
      do_load(1, 16'h5A5A, 1'b0, 1'b1);
      sb.push_back('{cyc + 2, 16'h5A5A});
      run_req(1, 1'b0, 1'b1, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc || wa !== 12'h0FF) begin
         bad++; $display("FAIL l4_preload got done=%0d addr=%h want done=%0d addr=0ff", d, wa, e.done_cyc);
      end
      do_load(1, 16'h1111, 1'b0, 1'b1);
      sb.push_back('{cyc + 7, 16'h5A5A});
      run_req(1, 1'b1, 1'b0, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc) begin bad++; $display("FAIL l4_latency got=%0d want=%0d", d, e.done_cyc); end
      total++;
      if (bd !== e.data) begin bad++; $display("FAIL l4_data got=%h want=%h", bd, e.data); end
      total++;
      if (nre !== 1) begin bad++; $display("FAIL l4_re_width got=%0d want=1", nre); end
      total++;
      if (bf !== 16'h1111) begin bad++; $display("FAIL l4_precapture got=%h want=1111", bf); end
   endtask

   task automatic test_rd_wr_both();
      int d; int nre; int nwe; logic [15:0] bf; logic [15:0] bd; logic [11:0] wa; logic pd; exp_t e;
      do_load(0, 16'h0042, 1'b0, 1'b1);
      sb.push_back('{cyc + 4, 16'hBEEF});
      run_req(0, 1'b1, 1'b1, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc || bd !== e.data) begin
         bad++; $display("FAIL both_read got done=%0d data=%h want %0d %h", d, bd, e.done_cyc, e.data);
      end
      total++;
      if (nwe !== 0 || nre !== 1) begin bad++; $display("FAIL both_strobes got we=%0d re=%0d want 0 1", nwe, nre); end
      repeat (3) @(negedge clk);
      total++;
      if (proto_err[0] !== 1'b1) begin bad++; $display("FAIL both_err_sticky got=%b want=1", proto_err[0]); end
      sb.push_back('{cyc + 4, 16'hBEEF});
      run_req(0, 1'b1, 1'b0, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (bd !== e.data) begin bad++; $display("FAIL both_ram_intact got=%h want=%h", bd, e.data); end
   endtask

   task automatic test_busy_load();
      int d; exp_t e;
      pulse_reset();
      total++;
      if (proto_err[0] !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", proto_err[0]); end
      do_load(0, 16'h0123, 1'b1, 1'b0);
      sb.push_back('{cyc + 4, 16'hBEEF});
      rd[0] = 1'b1; mdr_out[0] = 1'b1;
      repeat (2) @(negedge clk);
      bus_in[0] = 16'h0777; mar_in[0] = 1'b1;
      @(negedge clk);
      mar_in[0] = 1'b0;
      total++;
      if (ram_addr[0] !== 12'h123 || proto_err[0] !== 1'b1) begin
         bad++; $display("FAIL busy_load got addr=%h err=%b want 123 1", ram_addr[0], proto_err[0]);
      end
      d = -1;
      for (int k = 0; k < 20; k++) begin
         if (mem_done[0]) begin d = cyc; break; end
         @(negedge clk);
      end
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc || bus_out[0] !== e.data) begin
         bad++; $display("FAIL busy_read got done=%0d data=%h want %0d %h", d, bus_out[0], e.done_cyc, e.data);
      end
      rd[0] = 1'b0; mdr_out[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int d; int nre; int nwe; int pulses; logic [15:0] bf; logic [15:0] bd; logic [11:0] wa; logic pd; exp_t e;
      rd[0] = 1'b1; mdr_out[0] = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1; rd[0] = 1'b0;
      @(negedge clk);
      total++;
      if (busy[0] !== 1'b0 || mem_done[0] !== 1'b0 || bus_out[0] !== 16'h0) begin
         bad++; $display("FAIL mid_reset got busy=%b done=%b mdr=%h want 0 0 0000", busy[0], mem_done[0], bus_out[0]);
      end
      reset = 1'b0;
      pulses = 0;
      repeat (5) begin @(negedge clk); if (mem_done[0]) pulses++; end
      total++;
      if (pulses !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", pulses); end
      mdr_out[0] = 1'b0;
      do_load(0, 16'h0123, 1'b1, 1'b0);
      sb.push_back('{cyc + 4, 16'hBEEF});
      run_req(0, 1'b1, 1'b0, d, bf, bd, nre, nwe, wa, pd);
      e = sb.pop_front();
      total++;
      if (d !== e.done_cyc || bd !== e.data) begin
         bad++; $display("FAIL mid_reread got done=%0d data=%h want %0d %h", d, bd, e.done_cyc, e.data);
      end
   endtask

   task automatic test_back_to_back();
      int d; int nre; int nwe; int first; int second; int start;
      logic [15:0] bf; logic [15:0] bd; logic [11:0] wa; logic pd; exp_t e;
      // Load and write request on the same edge: the write must use the new MAR/MDR.
      bus_in[0] = 16'h1200; mar_in[0] = 1'b1;
      @(negedge clk);
      bus_in[0] = 16'h1234; mar_in[0] = 1'b0; mdr_in[0] = 1'b1; wr[0] = 1'b1;
      @(negedge clk);
      mdr_in[0] = 1'b0; wr[0] = 1'b0;
      total++;
      if (ram_we[0] !== 1'b1 || ram_addr[0] !== 12'h200 || ram_wdata[0] !== 16'h1234) begin
         bad++; $display("FAIL same_edge_wr got we=%b addr=%h data=%h want 1 200 1234", ram_we[0], ram_addr[0], ram_wdata[0]);
      end
      repeat (2) @(negedge clk);
      start = cyc;
      sb.push_back('{start + 4, 16'h1234});
      sb.push_back('{start + 9, 16'h1234});
      rd[0] = 1'b1; mdr_out[0] = 1'b1;
      first = -1; second = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (mem_done[0]) begin
            if (first < 0) first = cyc;
            else begin second = cyc; break; end
         end
      end
      bd = bus_out[0];
      rd[0] = 1'b0; mdr_out[0] = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (first !== e.done_cyc) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", first, e.done_cyc); end
      e = sb.pop_front();
      total++;
      if (second !== e.done_cyc || bd !== e.data) begin
         bad++; $display("FAIL b2b_second got=%0d data=%h want %0d %h", second, bd, e.done_cyc, e.data);
      end
      total++;
      if (mem_done[0] !== 1'b0 || busy[0] !== 1'b0) begin
         bad++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", mem_done[0], busy[0]);
      end
      run_req(0, 1'b1, 1'b0, d, bf, bd, nre, nwe, wa, pd);
   endtask

   initial begin
      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         bus_in[s] = '0; mar_in[s] = 1'b0; mdr_in[s] = 1'b0;
         mdr_out[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_latency();
      test_rd_wr_both();
      test_busy_load();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
